// File: rtl/seven_seg_mux_ctrl.sv
// seven_seg_mux_ctrl: time-multiplexed N-digit common-anode seven-segment driver
// with digit masking, leading-zero suppression, dead time and per-frame snapshot.
module seven_seg_mux_ctrl #(
    parameter int DIGITS       = 4,
    parameter int ON_CYCLES    = 100000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        en_i,
    input  logic [4*DIGITS-1:0]         value_i,
    input  logic [DIGITS-1:0]           dp_i,
    input  logic [DIGITS-1:0]           digit_en_i,
    input  logic                        lz_blank_i,
    output logic [DIGITS-1:0]           anode_o,
    output logic [6:0]                  seg_o,
    output logic                        dp_n_o,
    output logic [$clog2(DIGITS)-1:0]   digit_idx_o,
    output logic                        frame_tick_o
);
    localparam int IW = $clog2(DIGITS);
    localparam int MX = ON_CYCLES > BLANK_CYCLES ? ON_CYCLES : BLANK_CYCLES;
    localparam int CW = $clog2(MX + 1) > 17 ? $clog2(MX + 1) : 17;
    localparam logic [CW-1:0] ON_LAST  = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] BL_LAST  = BLANK_CYCLES > 0 ? CW'(BLANK_CYCLES - 1) : '0;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BLANK = 2'd1;
    localparam logic [1:0] DRIVE = 2'd2;
    localparam logic [1:0] SLOT  = BLANK_CYCLES == 0 ? DRIVE : BLANK;

    logic [1:0]          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] val_q, val_d;
    logic [DIGITS-1:0]   dp_q, dp_d, msk_q, msk_d, supp;
    logic                lz_q, lz_d, cap, zero, lit;
    logic [3:0]          nib;
    logic [DIGITS-1:0]   anode_q;
    logic [6:0]          seg_q;
    logic                dpn_q, tick_q;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    // en=0 takes priority over any slot-end advance
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        cap     = 1'b0;
        if (!en_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else if (state_q == IDLE) begin
            state_d = SLOT;
            cnt_d   = '0;
            idx_d   = '0;
            cap     = 1'b1;
        end else if (state_q == BLANK) begin
            if (cnt_q == BL_LAST) begin
                state_d = DRIVE;
                cnt_d   = '0;
            end
        end else if (cnt_q == ON_LAST) begin
            state_d = SLOT;
            cnt_d   = '0;
            cap     = idx_q == LAST_IDX;
            idx_d   = idx_q == LAST_IDX ? '0 : idx_q + 1'b1;
        end
    end

    assign val_d = cap ? value_i    : val_q;
    assign dp_d  = cap ? dp_i       : dp_q;
    assign msk_d = cap ? digit_en_i : msk_q;
    assign lz_d  = cap ? lz_blank_i : lz_q;

    // a digit is suppressed when it and every digit above it is zero
    always_comb begin
        zero = lz_d;
        supp = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            zero    = zero & (val_d[4*i +: 4] == 4'h0);
            supp[i] = zero;
        end
    end

    assign nib = val_d[{idx_d, 2'b00} +: 4];
    assign lit = state_d == DRIVE && msk_d[idx_d] && !supp[idx_d];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            val_q   <= '0;
            dp_q    <= '0;
            msk_q   <= '0;
            lz_q    <= 1'b0;
            anode_q <= '1;
            seg_q   <= 7'h7F;
            dpn_q   <= 1'b1;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            val_q   <= val_d;
            dp_q    <= dp_d;
            msk_q   <= msk_d;
            lz_q    <= lz_d;
            anode_q <= lit ? ~(DIGITS'(1) << idx_d) : '1;
            seg_q   <= lit ? hex7(nib) : 7'h7F;
            dpn_q   <= ~(lit & dp_d[idx_d]);
            tick_q  <= cap;
        end
    end

    assign anode_o      = anode_q;
    assign seg_o        = seg_q;
    assign dp_n_o       = dpn_q;
    assign digit_idx_o  = idx_q;
    assign frame_tick_o = tick_q;
endmodule

// File: tb/tb_seven_seg_mux_ctrl.sv
// tb_seven_seg_mux_ctrl: scoreboard bench; a frame-position model predicts each cycle's
// outputs for a 4-digit (ON=3, BLANK=1) and an 8-digit (ON=1, BLANK=0) instance.
module tb_seven_seg_mux_ctrl;
    typedef struct {
        int         cyc;
        logic [7:0] an;
        logic [6:0] sg;
        logic       dpn;
        int         idx;
        logic       tk;
    } exp_t;

    typedef struct {
        bit          run;
        int          t;
        logic [31:0] v;
        logic [7:0]  p;
        logic [7:0]  m;
        bit          lz;
    } mst_t;

    logic        clk, reset, en, lz;
    logic [15:0] val_a;
    logic [3:0]  dp_a, msk_a, an_a;
    logic [31:0] val_b;
    logic [7:0]  dp_b, msk_b, an_b;
    logic [6:0]  sg_a, sg_b;
    logic        dpn_a, dpn_b, tk_a, tk_b;
    logic [1:0]  idx_a;
    logic [2:0]  idx_b;
    int          cyc, checks, failures;
    exp_t        qa[$], qb[$];
    logic [6:0]  hex_tbl [16];

    seven_seg_mux_ctrl #(.DIGITS(4), .ON_CYCLES(3), .BLANK_CYCLES(1)) dut_a (
        .clk_i(clk), .reset_i(reset), .en_i(en), .value_i(val_a), .dp_i(dp_a),
        .digit_en_i(msk_a), .lz_blank_i(lz), .anode_o(an_a), .seg_o(sg_a),
        .dp_n_o(dpn_a), .digit_idx_o(idx_a), .frame_tick_o(tk_a));

    seven_seg_mux_ctrl #(.DIGITS(8), .ON_CYCLES(1), .BLANK_CYCLES(0)) dut_b (
        .clk_i(clk), .reset_i(reset), .en_i(en), .value_i(val_b), .dp_i(dp_b),
        .digit_en_i(msk_b), .lz_blank_i(lz), .anode_o(an_b), .seg_o(sg_b),
        .dp_n_o(dpn_b), .digit_idx_o(idx_b), .frame_tick_o(tk_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        hex_tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    function automatic exp_t predict(int d, int b, int o, mst_t s);
        exp_t e;
        int slot, off;
        bit lit;
        e.cyc = 0; e.an = 8'hFF; e.sg = 7'h7F; e.dpn = 1'b1; e.idx = 0; e.tk = 1'b0;
        if (s.run) begin
            slot  = s.t / (b + o);
            off   = s.t % (b + o);
            e.idx = slot;
            e.tk  = s.t == 0;
            lit   = off >= b && s.m[slot] && !(s.lz && slot > 0 && (s.v >> (4 * slot)) == 0);
            if (lit) begin
                e.an  = ~(8'd1 << slot);
                e.sg  = hex_tbl[4'((s.v >> (4 * slot)) & 32'hF)];
                e.dpn = ~s.p[slot];
            end
        end
        return e;
    endfunction

    function automatic mst_t step(int d, int b, int o, mst_t s, bit rst, bit e,
                                  logic [31:0] v, logic [7:0] p, logic [7:0] m, bit l);
        bit capture = 1'b0;
        if (rst) s = '{default: 0};
        else if (!e) s.run = 1'b0;
        else if (!s.run) begin
            s.run = 1'b1; s.t = 0; capture = 1'b1;
        end else begin
            s.t++;
            if (s.t == d * (b + o)) begin
                s.t = 0; capture = 1'b1;
            end
        end
        if (capture) begin
            s.v = v; s.p = p; s.m = m; s.lz = l;
        end
        return s;
    endfunction

    function automatic logic [31:0] rnd_val();
        logic [31:0] r = '0;
        for (int i = 0; i < 8; i++)
            r[4*i +: 4] = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(0, 15));
        return r;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (qa.size() > 0 && qa[0].cyc == cyc) begin
            e = qa.pop_front();
            chk("a_anode", {28'h0, an_a}, {24'h0, e.an[3:0]});
            chk("a_seg", {25'h0, sg_a}, {25'h0, e.sg});
            chk("a_dp_n", {31'h0, dpn_a}, {31'h0, e.dpn});
            chk("a_idx", {30'h0, idx_a}, e.idx);
            chk("a_tick", {31'h0, tk_a}, {31'h0, e.tk});
        end
        if (qb.size() > 0 && qb[0].cyc == cyc) begin
            e = qb.pop_front();
            chk("b_anode", {24'h0, an_b}, {24'h0, e.an});
            chk("b_seg", {25'h0, sg_b}, {25'h0, e.sg});
            chk("b_dp_n", {31'h0, dpn_b}, {31'h0, e.dpn});
            chk("b_idx", {29'h0, idx_b}, e.idx);
            chk("b_tick", {31'h0, tk_b}, {31'h0, e.tk});
        end
    end

    initial begin
        mst_t ma, mb;
        exp_t ea, eb, cur_a;
        bit   do_rst, rst_done;
        checks = 0; failures = 0; rst_done = 1'b0;
        reset = 1'b1; en = 1'b0; lz = 1'b0;
        val_a = '0; dp_a = '0; msk_a = '0; val_b = '0; dp_b = '0; msk_b = '0;
        ma = '{default: 0}; mb = '{default: 0};
        cur_a = predict(4, 1, 3, ma);
        @(posedge clk); #1;
        chk("rst_anode_a", {28'h0, an_a}, 32'hF);
        chk("rst_seg_a", {25'h0, sg_a}, 32'h7F);
        chk("rst_dpn_a", {31'h0, dpn_a}, 32'h1);
        chk("rst_idx_a", {30'h0, idx_a}, 32'h0);
        chk("rst_tick_a", {31'h0, tk_a}, 32'h0);
        chk("rst_anode_b", {24'h0, an_b}, 32'hFF);
        for (int k = 0; k < 2400; k++) begin
            @(posedge clk); #1;
            reset = 1'b0;
            val_b = rnd_val();
            dp_b  = 8'($urandom);
            msk_b = 8'($urandom) | 8'($urandom);
            case (k / 400)
                0: begin en = 1'b1; val_a = 16'h1234; dp_a = 4'b0100; msk_a = 4'hF; lz = 1'b0; end
                1: begin en = 1'b1; val_a = 16'h0070; dp_a = 4'($urandom); msk_a = 4'hF; lz = 1'b1; end
                2: begin
                    en = 1'b1; dp_a = 4'b0000; msk_a = 4'b1010; lz = 1'b0;
                    val_a = (k % 23) < 11 ? 16'h1111 : 16'h2222;
                end
                default: begin
                    en    = $urandom_range(0, 14) != 0;
                    val_a = rnd_val() >> 16;
                    dp_a  = 4'($urandom);
                    msk_a = 4'($urandom) | 4'($urandom);
                    lz    = 1'($urandom);
                end
            endcase
            do_rst = k >= 2200 && !rst_done && cur_a.an[3:0] != 4'hF;
            ma = step(4, 1, 3, ma, do_rst, en, {16'h0, val_a}, {4'h0, dp_a}, {4'h0, msk_a}, lz);
            mb = step(8, 0, 1, mb, do_rst, en, val_b, dp_b, msk_b, lz);
            ea = predict(4, 1, 3, ma); ea.cyc = cyc + 1;
            eb = predict(8, 0, 1, mb); eb.cyc = cyc + 1;
            qa.push_back(ea);
            qb.push_back(eb);
            cur_a = ea;
            if (do_rst) begin
                rst_done = 1'b1;
                #5 reset = 1'b1;
                #1;
                chk("async_rst_anode", {28'h0, an_a}, 32'hF);
                chk("async_rst_seg", {25'h0, sg_a}, 32'h7F);
                chk("async_rst_idx", {30'h0, idx_a}, 32'h0);
                chk("async_rst_tick", {31'h0, tk_a}, 32'h0);
            end
        end
        repeat (2) @(posedge clk);
        #1;
        chk("reset_exercised", {31'h0, rst_done}, 32'h1);
        chk("queue_a_drained", qa.size(), 32'h0);
        chk("queue_b_drained", qb.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
